// File: rtl/video_pkg.sv
// Shared video overlay types: box record, overlay state encoding and coordinate width.
package video_pkg;

  localparam int COORD_W = 12;

  typedef struct packed {
    logic [COORD_W-1:0] l;
    logic [COORD_W-1:0] r;
    logic [COORD_W-1:0] t;
    logic [COORD_W-1:0] b;
  } box_t;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HOLD   = 2'd2
  } box_state_t;

  function automatic logic [COORD_W-1:0] sat_inc(input logic [COORD_W-1:0] v);
    if (v == 12'hFFF) begin
      return v;
    end else begin
      return v + 12'd1;
    end
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Pixel column/row counters and frame-boundary detect; also forms the first pipeline
// stage (registered syncs plus the coordinate of the pixel they belong to).
module video_timing_cnt
  import video_pkg::*;
(
  input  logic               pixelclk,
  input  logic               reset,
  input  logic               i_hs,
  input  logic               i_vs,
  input  logic               i_de,
  output logic               fb,
  output logic               hs_dly,
  output logic               vs_dly,
  output logic               de_dly,
  output logic [COORD_W-1:0] x_dly,
  output logic [COORD_W-1:0] y_dly
);

  logic [COORD_W-1:0] x_cnt_r;
  logic [COORD_W-1:0] y_cnt_r;
  logic               de_fall_s;
  logic [COORD_W-1:0] pix_x_s;
  logic [COORD_W-1:0] pix_y_s;

  // vs_dly/de_dly double as the previous-cycle samples for edge detection
  assign fb        = ~i_vs & vs_dly;
  assign de_fall_s = ~i_de & de_dly;
  assign pix_x_s   = fb ? 12'd0 : x_cnt_r;
  assign pix_y_s   = fb ? 12'd0 : y_cnt_r;

  // Counters and stage-1 registers
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      x_cnt_r <= 12'd0;
      y_cnt_r <= 12'd0;
      hs_dly  <= 1'b0;
      vs_dly  <= 1'b0;
      de_dly  <= 1'b0;
      x_dly   <= 12'd0;
      y_dly   <= 12'd0;
    end else begin
      hs_dly <= i_hs;
      vs_dly <= i_vs;
      de_dly <= i_de;
      x_dly  <= pix_x_s;
      y_dly  <= pix_y_s;
      if (fb) begin
        // A pixel on the boundary cycle is column 0, so the next one is column 1
        x_cnt_r <= i_de ? 12'd1 : 12'd0;
        y_cnt_r <= 12'd0;
      end else if (de_fall_s) begin
        x_cnt_r <= 12'd0;
        y_cnt_r <= sat_inc(y_cnt_r);
      end else if (i_de) begin
        x_cnt_r <= sat_inc(x_cnt_r);
      end else begin
        x_cnt_r <= x_cnt_r;
      end
    end
  end

endmodule

// File: rtl/box_overlay.sv
// Draws a rectangular outline of the per-frame latched target box onto the video stream,
// holding a lost box for a bounded number of frames. Two-cycle pixel latency.
module box_overlay
  import video_pkg::*;
#(
  parameter int                        IMG_WIDTH_LINE  = 1920,
  parameter int                        IMG_HEIGHT_LINE = 1080,
  parameter int                        IMG_WIDTH_DATA  = 24,
  parameter int                        LINE_WIDTH      = 2,
  parameter logic [IMG_WIDTH_DATA-1:0] BOX_COLOR       = 24'hFF0000,
  parameter int                        MISS_LIMIT      = 4
) (
  input  logic                      pixelclk,
  input  logic                      reset,
  input  logic [IMG_WIDTH_DATA-1:0] i_rgb,
  input  logic                      i_hs,
  input  logic                      i_vs,
  input  logic                      i_de,
  input  logic [COORD_W-1:0]        hcount_l,
  input  logic [COORD_W-1:0]        hcount_r,
  input  logic [COORD_W-1:0]        vcount_l,
  input  logic [COORD_W-1:0]        vcount_r,
  input  logic                      i_box_en,
  output logic [IMG_WIDTH_DATA-1:0] o_rgb,
  output logic                      o_hs,
  output logic                      o_vs,
  output logic                      o_de,
  output logic                      o_box_valid
);

  localparam logic [12:0] W13       = 13'(IMG_WIDTH_LINE);
  localparam logic [12:0] H13       = 13'(IMG_HEIGHT_LINE);
  localparam logic [12:0] LW13      = 13'(LINE_WIDTH);
  localparam logic [3:0]  MISS_LIM4 = 4'(MISS_LIMIT);

  logic                      fb_s, hs1_s, vs1_s, de1_s;
  logic [COORD_W-1:0]        x1_s, y1_s;
  logic [IMG_WIDTH_DATA-1:0] rgb1_r;
  box_state_t                state_r;
  logic [3:0]                miss_cnt_r;
  logic [3:0]                miss_inc_s;
  box_t                      sb_r;
  box_t                      cand_s;
  logic                      cand_ok_s;

  video_timing_cnt u_timing (
    .pixelclk (pixelclk),
    .reset    (reset),
    .i_hs     (i_hs),
    .i_vs     (i_vs),
    .i_de     (i_de),
    .fb       (fb_s),
    .hs_dly   (hs1_s),
    .vs_dly   (vs1_s),
    .de_dly   (de1_s),
    .x_dly    (x1_s),
    .y_dly    (y1_s)
  );

  assign cand_s     = '{l: hcount_l, r: hcount_r, t: vcount_l, b: vcount_r};
  assign cand_ok_s  = (hcount_l < hcount_r) && (vcount_l < vcount_r) &&
                      ({1'b0, hcount_r} < W13) && ({1'b0, vcount_r} < H13);
  assign miss_inc_s = miss_cnt_r + 4'd1;

  // Frame-boundary state machine: latch box, count misses, publish draw flag
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      state_r     <= ST_WAIT;
      miss_cnt_r  <= 4'd0;
      sb_r        <= '0;
      o_box_valid <= 1'b0;
    end else if (fb_s) begin
      if (!i_box_en) begin
        state_r     <= ST_WAIT;
        miss_cnt_r  <= 4'd0;
        o_box_valid <= 1'b0;
      end else begin
        case (state_r)
          ST_WAIT: begin
            if (cand_ok_s) begin
              sb_r        <= cand_s;
              miss_cnt_r  <= 4'd0;
              state_r     <= ST_ACTIVE;
              o_box_valid <= 1'b1;
            end else begin
              o_box_valid <= 1'b0;
            end
          end
          ST_ACTIVE: begin
            if (cand_ok_s) begin
              sb_r        <= cand_s;
              o_box_valid <= 1'b1;
            end else if (MISS_LIM4 == 4'd1) begin
              state_r     <= ST_WAIT;
              miss_cnt_r  <= 4'd0;
              o_box_valid <= 1'b0;
            end else begin
              miss_cnt_r  <= 4'd1;
              state_r     <= ST_HOLD;
              o_box_valid <= 1'b1;
            end
          end
          ST_HOLD: begin
            if (cand_ok_s) begin
              sb_r        <= cand_s;
              miss_cnt_r  <= 4'd0;
              state_r     <= ST_ACTIVE;
              o_box_valid <= 1'b1;
            end else if (miss_inc_s >= MISS_LIM4) begin
              state_r     <= ST_WAIT;
              miss_cnt_r  <= 4'd0;
              o_box_valid <= 1'b0;
            end else begin
              miss_cnt_r  <= miss_inc_s;
              o_box_valid <= 1'b1;
            end
          end
          default: begin
            state_r     <= ST_WAIT;
            miss_cnt_r  <= 4'd0;
            o_box_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  // Border bands in 13 bits; inner edges clamped so narrow boxes fill without wrapping
  logic [12:0] l13, r13, t13, b13, x13, y13;
  logic [12:0] left_raw_s, top_raw_s, left_hi_s, top_hi_s, right_lo_s, bot_lo_s;
  logic        in_x_s, in_y_s, band_v_s, band_h_s, border_s;

  assign l13        = {1'b0, sb_r.l};
  assign r13        = {1'b0, sb_r.r};
  assign t13        = {1'b0, sb_r.t};
  assign b13        = {1'b0, sb_r.b};
  assign x13        = {1'b0, x1_s};
  assign y13        = {1'b0, y1_s};
  assign left_raw_s = l13 + LW13 - 13'd1;
  assign top_raw_s  = t13 + LW13 - 13'd1;
  assign left_hi_s  = (left_raw_s > r13) ? r13 : left_raw_s;
  assign top_hi_s   = (top_raw_s > b13) ? b13 : top_raw_s;
  assign right_lo_s = (r13 + 13'd1 < l13 + LW13) ? l13 : (r13 + 13'd1 - LW13);
  assign bot_lo_s   = (b13 + 13'd1 < t13 + LW13) ? t13 : (b13 + 13'd1 - LW13);
  assign in_x_s     = (x13 >= l13) && (x13 <= r13);
  assign in_y_s     = (y13 >= t13) && (y13 <= b13);
  assign band_v_s   = ((x13 >= l13) && (x13 <= left_hi_s)) || ((x13 >= right_lo_s) && (x13 <= r13));
  assign band_h_s   = ((y13 >= t13) && (y13 <= top_hi_s)) || ((y13 >= bot_lo_s) && (y13 <= b13));
  assign border_s   = de1_s && (state_r != ST_WAIT) &&
                      ((in_y_s && band_v_s) || (in_x_s && band_h_s));

  // Stage-1 pixel register
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      rgb1_r <= {IMG_WIDTH_DATA{1'b0}};
    end else begin
      rgb1_r <= i_rgb;
    end
  end

  // Stage-2 output mux
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      o_rgb <= {IMG_WIDTH_DATA{1'b0}};
      o_hs  <= 1'b0;
      o_vs  <= 1'b0;
      o_de  <= 1'b0;
    end else begin
      o_hs <= hs1_s;
      o_vs <= vs1_s;
      o_de <= de1_s;
      if (!de1_s) begin
        o_rgb <= {IMG_WIDTH_DATA{1'b0}};
      end else if (border_s) begin
        o_rgb <= BOX_COLOR;
      end else begin
        o_rgb <= rgb1_r;
      end
    end
  end

endmodule

// File: tb/tb_box_overlay.sv
// Randomized-pixel bench for box_overlay on a 64x48 frame, checked every cycle
// against a frame-level behavioural model plus literal pixel pins.
module tb_box_overlay;

  localparam int W = 64;
  localparam int H = 48;
  localparam int LW = 2;
  localparam int LIMIT = 4;
  localparam logic [23:0] COLOR = 24'hFF0000;

  logic        pixelclk = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] i_rgb = 24'd0;
  logic        i_hs = 1'b0, i_vs = 1'b0, i_de = 1'b0;
  logic [11:0] hcount_l = 12'd0, hcount_r = 12'd0, vcount_l = 12'd0, vcount_r = 12'd0;
  logic        i_box_en = 1'b0;
  logic [23:0] o_rgb;
  logic        o_hs, o_vs, o_de, o_box_valid;

  always #5 pixelclk = ~pixelclk;

  box_overlay #(
    .IMG_WIDTH_LINE(W), .IMG_HEIGHT_LINE(H), .IMG_WIDTH_DATA(24),
    .LINE_WIDTH(LW), .BOX_COLOR(COLOR), .MISS_LIMIT(LIMIT)
  ) dut (
    .pixelclk(pixelclk), .reset(reset), .i_rgb(i_rgb), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .hcount_l(hcount_l), .hcount_r(hcount_r), .vcount_l(vcount_l), .vcount_r(vcount_r),
    .i_box_en(i_box_en), .o_rgb(o_rgb), .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
    .o_box_valid(o_box_valid)
  );

  typedef struct {
    logic [26:0] out;
    bit          valid_after;
    int          pin;
    int          frame;
    int          px;
    int          py;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   frame_no = 0;

  // Model: box drawn iff armed; armed by a valid enabled boundary, lost after LIMIT misses
  bit m_armed = 0;
  bit m_prev_vs = 0;
  int m_miss = 0;
  int m_l = 0, m_r = 0, m_t = 0, m_b = 0;

  int chg_line = -1;
  logic [11:0] chg_l = 12'd0, chg_r = 12'd0;
  int rst_line = -1;

  function automatic bit in_border(int x, int y);
    if (x < m_l || x > m_r || y < m_t || y > m_b) return 1'b0;
    return (x - m_l < LW) || (m_r - x < LW) || (y - m_t < LW) || (m_b - y < LW);
  endfunction

  // Hand-derived expectations: 1 = must be box colour, 2 = must pass through
  function automatic int pin_code(int f, int x, int y);
    case (f)
      0: begin
        if ((x == 10 && y == 5) || (x == 11 && y == 15) || (x == 20 && y == 14) ||
            (x == 15 && y == 6)) return 1;
        if ((x == 12 && y == 7) || (x == 21 && y == 10) || (x == 15 && y == 7) ||
            (x == 9 && y == 5)) return 2;
      end
      1: begin
        if (x == 10 && y == 25) return 1;
        if (x == 40 && y == 25) return 2;
      end
      2: begin
        if (x == 40 && y == 25) return 1;
        if (x == 10 && y == 25) return 2;
      end
      5: if (x == 40 && y == 5) return 1;
      6: if (x == 40 && y == 5) return 2;
      7: if (x == 40 && y == 5) return 2;
      8: begin
        if ((x == 10 || x == 11) && y == 9) return 1;
        if ((x == 12 || x == 62 || x == 63) && y == 9) return 2;
      end
      9: begin
        if (x == 40 && y == 5) return 1;
        if (x == 40 && y == 10) return 2;
      end
      10: if (x == 40 && y == 10) return 1;
      default: return 0;
    endcase
    return 0;
  endfunction

  task automatic model_boundary();
    bit ok;
    ok = (hcount_l < hcount_r) && (vcount_l < vcount_r) && (int'(hcount_r) < W) && (int'(vcount_r) < H);
    if (!i_box_en) begin
      m_armed = 0;
    end else if (ok) begin
      m_armed = 1; m_miss = 0;
      m_l = int'(hcount_l); m_r = int'(hcount_r); m_t = int'(vcount_l); m_b = int'(vcount_r);
    end else if (m_armed) begin
      m_miss++;
      if (m_miss >= LIMIT) m_armed = 0;
    end
  endtask

  task automatic drive(input bit rst, input bit hs, input bit vs, input bit de, input int px, input int py);
    ent_t e;
    int pin;
    logic [23:0] rgb_o;
    @(posedge pixelclk);
    #1;
    pin = de ? pin_code(frame_no, px, py) : 0;
    reset = rst; i_hs = hs; i_vs = vs; i_de = de;
    i_rgb = (pin == 2) ? 24'h00FF00 : 24'($urandom);
    e.frame = frame_no; e.px = px; e.py = py;
    if (rst) begin
      m_armed = 0; m_prev_vs = 0; m_miss = 0;
      if (q.size() > 0) begin
        ent_t p;
        p = q[q.size()-1];
        p.out = 27'd0; p.pin = 0;
        q[q.size()-1] = p;
      end
      e.out = 27'd0; e.valid_after = 0; e.pin = 0;
    end else begin
      if (m_prev_vs && !vs) model_boundary();
      m_prev_vs = vs;
      if (!de) rgb_o = 24'd0;
      else if (m_armed && in_border(px, py)) rgb_o = COLOR;
      else rgb_o = i_rgb;
      e.out = {rgb_o, hs, vs, de}; e.valid_after = m_armed; e.pin = pin;
    end
    q.push_back(e);
  endtask

  task automatic run_frame();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1, 1'b0, -1, -1);
    drive(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    for (int row = 0; row < H; row++) begin
      if (row == chg_line) begin hcount_l = chg_l; hcount_r = chg_r; end
      for (int c = 0; c < 4; c++) drive(1'b0, c < 2, 1'b0, 1'b0, -1, -1);
      for (int col = 0; col < W; col++) drive(row == rst_line && col < 2, 1'b0, 1'b0, 1'b1, col, row);
    end
    frame_no++;
    chg_line = -1; rst_line = -1;
  endtask

  task automatic set_box(input int l, input int r, input int t, input int b, input bit en);
    hcount_l = 12'(l); hcount_r = 12'(r); vcount_l = 12'(t); vcount_r = 12'(b); i_box_en = en;
  endtask

  // Output compare: entry k is visible two edges after it was driven
  always @(negedge pixelclk) begin
    if (q.size() >= 3) begin
      ent_t e;
      e = q.pop_front();
      checks++;
      if ({o_rgb, o_hs, o_vs, o_de} !== e.out) begin
        errors++;
        $display("FAIL pixel f%0d (%0d,%0d): got rgb=%h hs/vs/de=%b%b%b want rgb=%h hs/vs/de=%b",
                 e.frame, e.px, e.py, o_rgb, o_hs, o_vs, o_de, e.out[26:3], e.out[2:0]);
      end
      checks++;
      if (o_box_valid !== q[0].valid_after) begin
        errors++;
        $display("FAIL box_valid f%0d (%0d,%0d): got %b want %b", e.frame, e.px, e.py, o_box_valid, q[0].valid_after);
      end
      if (e.pin != 0) begin
        checks++;
        if ((o_rgb === COLOR) != (e.pin == 1)) begin
          errors++;
          $display("FAIL pin f%0d (%0d,%0d): got rgb=%h want %s", e.frame, e.px, e.py, o_rgb,
                   (e.pin == 1) ? "box colour" : "passthrough");
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, -1, -1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    set_box(10, 20, 5, 15, 1'b1); run_frame();                 // f0 basic box
    set_box(10, 20, 5, 30, 1'b1);
    chg_line = 20; chg_l = 12'd40; chg_r = 12'd50; run_frame(); // f1 mid-frame change
    run_frame();                                               // f2 uses l=40
    set_box(30, 20, 5, 30, 1'b1);
    for (int f = 0; f < 4; f++) run_frame();                   // f3..f6 invalid
    set_box(40, 50, 5, 30, 1'b0); run_frame();                 // f7 disabled
    set_box(10, 11, 5, 15, 1'b1); run_frame();                 // f8 narrow
    set_box(40, 50, 5, 30, 1'b1); rst_line = 7; run_frame();   // f9 reset mid-frame
    run_frame();                                               // f10 redraw
    for (int f = 0; f < 3; f++) begin                          // f11..f13 random
      set_box($urandom_range(0, 63), $urandom_range(0, 70), $urandom_range(0, 47),
              $urandom_range(0, 52), $urandom_range(0, 3) != 0);
      chg_line = $urandom_range(0, H - 1);
      chg_l = 12'($urandom_range(0, 63)); chg_r = 12'($urandom_range(0, 63));
      run_frame();
    end
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, -1, -1);
    @(posedge pixelclk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
